// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext,rel,code} events and queues them.
// Latency: event written on the edge that samples its final byte; visible at the head one cycle later.
// Backpressure: out_valid/out_ready handshake; a push into a full queue is dropped and flags sticky ovf.

module ps2_scan_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_done,
    output logic             push_drop,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop_en;

    assign full      = (count == CW'(DEPTH));
    assign pop_vld   = (count != '0);
    assign pop_en    = pop_vld && pop_rdy;
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign push_done = push_vld && (!full || pop_en);
    assign push_drop = push_vld && full && !pop_en;
    assign pop_dat   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_done) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_done, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module ps2_scan_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_rel,
    output logic       err_pulse,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic [7:0] last_code
);
    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    localparam int TW = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          err_nxt;
    logic          push_vld;
    evt_t          push_dat;
    evt_t          head;
    logic          push_done;
    logic          push_drop;

    // A byte arriving on the expiry cycle wins because to_hit requires !in_valid.
    assign to_hit = !in_valid && (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt     = state;
        err_nxt       = 1'b0;
        push_vld      = 1'b0;
        push_dat      = '0;
        push_dat.code = in_data;
        push_dat.ext  = (state == GOT_E0) || (state == GOT_E0F0);
        push_dat.rel  = (state == GOT_F0) || (state == GOT_E0F0);
        if (in_valid) begin
            if (in_err || in_data == 8'h00 || in_data == 8'hFF) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else if (in_data == 8'hE0) begin
                if (state == IDLE) begin
                    state_nxt = GOT_E0;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end else if (in_data == 8'hF0) begin
                case (state)
                    IDLE:    state_nxt = GOT_F0;
                    GOT_E0:  state_nxt = GOT_E0F0;
                    default: begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                endcase
            end else begin
                push_vld  = 1'b1;
                state_nxt = IDLE;
            end
        end else if (to_hit) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            err_pulse <= 1'b0;
            ovf       <= 1'b0;
            last_code <= 8'h00;
        end else begin
            state     <= state_nxt;
            err_pulse <= err_nxt;
            if (in_valid || to_hit || state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (push_done) begin
                last_code <= push_dat.code;
            end
        end
    end

    ps2_scan_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .push_done (push_done),
        .push_drop (push_drop),
        .pop_vld   (out_valid),
        .pop_rdy   (out_ready),
        .pop_dat   (head)
    );

    assign out_code = head.code;
    assign out_ext  = head.ext;
    assign out_rel  = head.rel;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios then random traffic, every cycle compared to a queue model.
module tb_ps2_scan_decoder;
    localparam int D = 4;
    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_err = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_rel;
    logic       err_pulse;
    logic       ovf;
    logic [7:0] last_code;

    ps2_scan_decoder #(
        .FIFO_DEPTH  (D),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_err    (in_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_rel   (out_rel),
        .err_pulse (err_pulse),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .last_code (last_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: prefix bytes seen so far, idle edges since the last byte, event queue.
    logic [7:0] pfx[$];
    logic [9:0] q[$];
    int         idle = 0;
    logic       exp_err = 1'b0;
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_last = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit has(input logic [7:0] b);
        foreach (pfx[i]) begin
            if (pfx[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d,
                              input logic e, input logic rdy, input logic clr);
        bit         have_evt;
        logic [9:0] evt;
        bit         full;
        bit         pop;
        bit         drop;
        have_evt = 1'b0;
        evt      = '0;
        drop     = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            q.delete();
            pfx.delete();
            idle     = 0;
            exp_ovf  = 1'b0;
            exp_last = 8'h00;
            return;
        end
        if (v) begin
            idle = 0;
            if (e || d == 8'h00 || d == 8'hFF) begin
                exp_err = 1'b1;
                pfx.delete();
            end else if (d == 8'hE0) begin
                if (pfx.size() == 0) pfx.push_back(d);
                else begin
                    exp_err = 1'b1;
                    pfx.delete();
                end
            end else if (d == 8'hF0) begin
                if (!has(8'hF0)) pfx.push_back(d);
                else begin
                    exp_err = 1'b1;
                    pfx.delete();
                end
            end else begin
                have_evt = 1'b1;
                evt      = {has(8'hE0), has(8'hF0), d};
                pfx.delete();
            end
        end else if (pfx.size() > 0) begin
            idle++;
            if (idle == T) begin
                exp_err = 1'b1;
                pfx.delete();
                idle = 0;
            end
        end
        full = (q.size() == D);
        pop  = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (have_evt) begin
            if (full && !pop) drop = 1'b1;
            else begin
                q.push_back(evt);
                exp_last = d;
            end
        end
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
    endtask

    task automatic compare();
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_code", out_code, q[0][7:0]);
            chk("out_ext", out_ext, q[0][9]);
            chk("out_rel", out_rel, q[0][8]);
        end
        chk("err_pulse", err_pulse, exp_err);
        chk("ovf", ovf, exp_ovf);
        chk("last_code", last_code, exp_last);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic e, input logic rdy, input logic clr);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_err    = e;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_edge(r, v, d, e, rdy, clr);
        cyc++;
        #1;
        compare();
    endtask

    task automatic send(input logic [7:0] d, input logic rdy);
        step(1'b0, 1'b1, d, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle_n(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic       slow;
        logic       v;
        logic [7:0] d;
        int         pick;

        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_code", out_code, 8'h00);
        chk("rst_ext", out_ext, 1'b0);
        chk("rst_rel", out_rel, 1'b0);

        // make then break of the same key
        send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        idle_n(2, 1'b1);

        // extended break
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        chk("last_075", last_code, 8'h75);
        idle_n(2, 1'b1);

        // overflow: five makes into a depth-4 queue, then drain and clear
        send(8'h16, 1'b0); send(8'h1E, 1'b0); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b0);
        chk("ovf_set", ovf, 1'b1);
        idle_n(5, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // full queue with simultaneous push and pop
        send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);
        send(8'h15, 1'b1);
        chk("ovf_fullpp", ovf, 1'b0);
        idle_n(5, 1'b1);

        // timeout after a lone E0, then a plain make
        send(8'hE0, 1'b1);
        idle_n(T, 1'b1);
        send(8'h1C, 1'b1);
        idle_n(1, 1'b1);

        // byte on the expiry cycle beats the timeout
        send(8'hE0, 1'b0);
        idle_n(T - 1, 1'b0);
        send(8'h6B, 1'b0);
        chk("prec_ext", out_ext, 1'b1);
        idle_n(2, 1'b1);

        // errored byte after F0, then a clean one
        send(8'hF0, 1'b1);
        step(1'b0, 1'b1, 8'h1C, 1'b1, 1'b1, 1'b0);
        send(8'h1C, 1'b1);
        idle_n(1, 1'b1);

        // illegal prefixes and keyboard overrun codes
        send(8'hE0, 1'b1); send(8'hE0, 1'b1);
        send(8'hF0, 1'b1); send(8'hF0, 1'b1);
        send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'hE0, 1'b1);
        send(8'hE0, 1'b1); send(8'h00, 1'b1); send(8'hFF, 1'b1);
        idle_n(1, 1'b1);

        // reset with a partial prefix and two events queued
        send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'hE0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_flush", out_valid, 1'b0);
        send(8'h74, 1'b0);
        idle_n(2, 1'b1);

        slow = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) slow = ~slow;
            v    = ($urandom_range(0, 99) < 45);
            pick = $urandom_range(0, 19);
            if (pick < 4) d = 8'hE0;
            else if (pick < 8) d = 8'hF0;
            else if (pick == 8) d = 8'h00;
            else if (pick == 9) d = 8'hFF;
            else d = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 999) == 0), v, d, ($urandom_range(0, 29) == 0),
                 slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 99) == 0) idle_n(T + 3, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
